// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and frame FSM state for the PS/2 keyboard receiver
package ps2_pkg;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam int KEY_EVT_W = 9;
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} frame_state_t;
endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous key-event FIFO with a registered head output
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W = KEY_EVT_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0] cnt_nxt;
    logic full, pop_ok, push_ok;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign pop_ok = pop & ~empty;
    // a full FIFO still accepts a push when the head leaves on the same edge
    assign push_ok = push & (~full | pop_ok);
    assign rd_nxt = rd_ptr + AW'(pop_ok);
    assign cnt_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            dout <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_nxt;
            count <= cnt_nxt;
            // head tracks the next entry; when draining to empty it keeps its last value
            if (cnt_nxt != '0) dout <= (count == (AW+1)'(pop_ok)) ? din : mem[rd_nxt];
        end
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard frame receiver with break-prefix folding and event FIFO
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [KEY_EVT_W-1:0] data,
    output logic                 ready,
    input  logic                 nextdata_n,
    output logic                 overflow,
    output logic                 frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [2:0] clk_s, dat_s;
    logic fall, bit_in, valid, push, full, empty, pop_ok, break_pending;
    logic [3:0] bitcnt;
    logic [9:0] shreg;
    logic [7:0] code;
    logic [TW-1:0] wd;
    logic [AW:0] fill;
    frame_state_t state;
    assign fall = clk_s[2] & ~clk_s[1];
    assign bit_in = dat_s[2];
    // shreg holds {stop, parity, byte} once the tenth bit has shifted in
    assign code = shreg[7:0];
    assign valid = (^shreg[8:0]) & shreg[9];
    assign push = (state == CHECK) & valid & (code != PS2_BREAK) & (code != PS2_EXT);
    assign full = fill == (AW+1)'(FIFO_DEPTH);
    assign ready = ~empty;
    assign pop_ok = ~nextdata_n & ~empty;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            clk_s <= 3'b111;
            dat_s <= 3'b111;
            state <= IDLE;
            bitcnt <= '0;
            shreg <= '0;
            wd <= '0;
            break_pending <= 1'b0;
            frame_err <= 1'b0;
            overflow <= 1'b0;
        end else begin
            clk_s <= {clk_s[1:0], ps2_clk};
            dat_s <= {dat_s[1:0], ps2_data};
            frame_err <= 1'b0;
            overflow <= pop_ok ? 1'b0 : (push & full) ? 1'b1 : overflow;
            case (state)
                IDLE: begin
                    wd <= '0;
                    if (fall && !bit_in) begin
                        state <= SHIFT;
                        bitcnt <= '0;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        shreg <= {bit_in, shreg[9:1]};
                        wd <= '0;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd9) state <= CHECK;
                    end else if (wd == TW'(TIMEOUT_CYC - 1)) begin
                        state <= IDLE;
                        frame_err <= 1'b1;
                    end else begin
                        wd <= wd + TW'(1);
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    frame_err <= ~valid;
                    if (valid && code == PS2_BREAK) break_pending <= 1'b1;
                    else if (push) break_pending <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    ps2_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(KEY_EVT_W)) u_fifo (
        .clk(clk),
        .rstn(rstn),
        .push(push),
        .din({break_pending, code}),
        .pop(~nextdata_n),
        .dout(data),
        .empty(empty),
        .count(fill)
    );
endmodule
